inst_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer between the combinational instruction ROM and the decode stage. It owns the fetch program counter, drives the ROM address, and captures each returned instruction word with its PC into a 2-entry prefetch queue. Decode consumes entries through a valid/ready handshake and can redirect fetch for JMP or skip one instruction for taken BEQ/BNE.

---
 rtl/inst_fetch_ctrl.sv | 123 ++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, drives the ROM, and buffers words in a 2-entry queue.
// Optional build macro FETCH_NOP_HALT_EN: an all-zero fetched word halts fetch until redirect/reset.
`ifndef InstAddrBus
`define InstAddrBus 8
`endif
`ifndef InstBusWidth
`define InstBusWidth 32
`endif

module inst_fetch_ctrl #(
    parameter int ADDR_W = `InstAddrBus,
    parameter int INST_W = `InstBusWidth,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic [ADDR_W-1:0] romAddr,
    input  logic [INST_W-1:0] romInst,
    output logic              instValid,
    output logic [INST_W-1:0] instOut,
    output logic [ADDR_W-1:0] pcOut,
    input  logic              instReady,
    input  logic              redirectValid,
    input  logic [ADDR_W-1:0] redirectPc,
    input  logic              skip,
    output logic              halted
);
    localparam int DEPTH = 2;

    logic [ADDR_W-1:0] pc_reg;
    logic [1:0]        count_reg;
    logic [ADDR_W-1:0] q_pc   [DEPTH];
    logic [INST_W-1:0] q_inst [DEPTH];

    logic       pop;
    logic       skip_pop;
    logic       fetch_ok;
    logic       push;
    logic       halt_now;
    logic       halted_int;
    logic [1:0] wr_idx;

    assign instValid = (count_reg != 2'd0);
    assign pop       = instValid & instReady;
    assign skip_pop  = skip & pop;
    assign fetch_ok  = enable & ~halted_int & ~redirectValid & ~skip_pop
                     & ((count_reg < 2'd2) | pop);
    assign push      = fetch_ok & ~halt_now;
    // Slot that receives the new word after any same-cycle pop has shifted the queue.
    assign wr_idx    = count_reg - {1'b0, pop};

`ifdef FETCH_NOP_HALT_EN
    logic halted_reg;

    assign halt_now   = fetch_ok & (romInst == '0);
    assign halted_int = halted_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            halted_reg <= 1'b0;
        end else if (redirectValid) begin
            halted_reg <= 1'b0;
        end else if (halt_now) begin
            halted_reg <= 1'b1;
        end
    end
`else
    assign halt_now   = 1'b0;
    assign halted_int = 1'b0;
`endif

    assign halted  = halted_int;
    assign romAddr = pc_reg;
    assign pcOut   = q_pc[0];
    assign instOut = q_inst[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg    <= RESET_PC;
            count_reg <= 2'd0;
        end else if (redirectValid) begin
            pc_reg    <= redirectPc;
            count_reg <= 2'd0;
        end else if (skip_pop) begin
            pc_reg    <= q_pc[0] + ADDR_W'(2);
            count_reg <= 2'd0;
        end else begin
            if (push) begin
                pc_reg <= pc_reg + ADDR_W'(1);
            end
            count_reg <= count_reg - {1'b0, pop} + {1'b0, push};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            // The last slot has no successor; it simply holds on a pop.
            localparam int SRC = (gi < DEPTH - 1) ? gi + 1 : gi;

            logic [ADDR_W-1:0] pc_reg;
            logic [INST_W-1:0] inst_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    pc_reg   <= '0;
                    inst_reg <= '0;
                end else if (push && (wr_idx == 2'(gi))) begin
                    pc_reg   <= romAddr;
                    inst_reg <= romInst;
                end else if (pop) begin
                    pc_reg   <= q_pc[SRC];
                    inst_reg <= q_inst[SRC];
                end
            end

            assign q_pc[gi]   = pc_reg;
            assign q_inst[gi] = inst_reg;
        end
    endgenerate

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: directed scenarios then random traffic against a queue-based model.
module tb_inst_fetch_ctrl;
    localparam int ADDR_W = 8;
    localparam int INST_W = 32;
`ifdef FETCH_NOP_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic [ADDR_W-1:0] romAddr;
    logic [INST_W-1:0] romInst;
    logic              instValid;
    logic [INST_W-1:0] instOut;
    logic [ADDR_W-1:0] pcOut;
    logic              instReady = 1'b0;
    logic              redirectValid = 1'b0;
    logic [ADDR_W-1:0] redirectPc = '0;
    logic              skip = 1'b0;
    logic              halted;

    logic [INST_W-1:0] rom [256];
    assign romInst = rom[romAddr];

    always #5 clk = ~clk;

    inst_fetch_ctrl #(.ADDR_W(ADDR_W), .INST_W(INST_W), .RESET_PC('0)) dut (
        .clk(clk), .rst(rst), .enable(enable), .romAddr(romAddr), .romInst(romInst),
        .instValid(instValid), .instOut(instOut), .pcOut(pcOut), .instReady(instReady),
        .redirectValid(redirectValid), .redirectPc(redirectPc), .skip(skip), .halted(halted)
    );

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } ent_t;

    ent_t              mq[$];
    logic [ADDR_W-1:0] mpc;
    logic              mhalt;
    int                errors = 0;
    int                checks = 0;
    int                cyc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        check("romAddr", 64'(romAddr), 64'(mpc));
        check("instValid", 64'(instValid), 64'(mq.size() > 0));
        check("halted", 64'(halted), 64'(mhalt));
        if (mq.size() > 0) begin
            check("pcOut", 64'(pcOut), 64'(mq[0].pc));
            check("instOut", 64'(instOut), 64'(mq[0].inst));
        end
    endtask

    // Behavioural next-state rules, evaluated on the inputs applied this cycle.
    task automatic model_update();
        int  n;
        bit  p;
        n = mq.size();
        p = (n > 0) && instReady;
        if (rst) begin
            mq.delete();
            mpc   = '0;
            mhalt = 1'b0;
        end else if (redirectValid) begin
            mq.delete();
            mpc   = redirectPc;
            mhalt = 1'b0;
        end else if (skip && p) begin
            mpc = mq[0].pc + 8'd2;
            mq.delete();
        end else begin
            if (p) void'(mq.pop_front());
            if (enable && !mhalt && (n < 2 || p)) begin
                if (HALT_EN && rom[mpc] == '0) begin
                    mhalt = 1'b1;
                end else begin
                    mq.push_back('{pc: mpc, inst: rom[mpc]});
                    mpc = mpc + 8'd1;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic en, input logic rdy,
                        input logic rv, input logic [ADDR_W-1:0] rp, input logic sk);
        rst = r; enable = en; instReady = rdy;
        redirectValid = rv; redirectPc = rp; skip = sk;
        model_update();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_all();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = $urandom() | 32'h1;
        rom[11] = '0;
        mpc = '0;
        mhalt = 1'b0;
        @(negedge clk);

        // Reset values
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("rst_instOut", 64'(instOut), 64'h0);
        check("rst_pcOut", 64'(pcOut), 64'h0);

        // Streaming from reset (also walks past the all-zero word at 11)
        for (int i = 0; i < 14; i++) step(0, 1, 1, 0, 0, 0);

        // Backpressure, then release, then reset with a full queue
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 0);
        check("bp_romAddr_hold", 64'(romAddr), 64'd2);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        check("midrst_valid", 64'(instValid), 64'd0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0, 0);

        // Redirect with pc 1,2 queued
        step(0, 1, 0, 1, 8'd1, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
        step(0, 1, 1, 1, 8'd4, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0);
        // Redirect and skip together: redirect wins
        step(0, 1, 1, 1, 8'd20, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0);

        // Skip popping pc 8
        step(0, 1, 1, 1, 8'd8, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0, 0);

        // Address wrap
        step(0, 1, 1, 1, 8'd253, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0, 0);

        // Stream into the all-zero word, then redirect to 0
        step(0, 1, 1, 1, 8'd8, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 1, 8'd0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            logic r, rv, sk;
            logic [ADDR_W-1:0] rp;
            r  = ($urandom_range(0, 99) < 2);
            rv = ($urandom_range(0, 99) < 6);
            sk = ($urandom_range(0, 99) < 10);
            rp = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom_range(0, 20));
            step(r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), rv, rp, sk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
